// File: rtl/mips_fetch_unit.sv
// Purpose: instruction-fetch front end; keeps up to DEPTH fetches in flight and buffers words in order.
// Latency: a response accepted at edge N is at the decode head after edge N; 1 instr/cycle sustained.
// Backpressure: credit-based; requests stop while FIFO occupancy + in-flight reaches DEPTH.
//
// Ports:
//   clk, reset            clock (rising edge) and asynchronous active-low reset
//   fetch_en              allow new requests; responses are always accepted
//   redirect_valid/pc     one-cycle jump/branch; flushes buffer, drops stale responses
//   imem_req_*            valid/ready request port, address = current fetch PC
//   imem_rsp_*            in-order responses, no backpressure
//   instr_*               {pc, instr} to decode over valid/ready; pc/data read 0 when empty

// Purpose: small in-order FIFO with synchronous flush and zeroed head when empty.
// Latency: a push at edge N is visible at the head after edge N.
// Backpressure: none internally; the caller guarantees no push when full and no pop when empty.
module mips_fetch_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       push_vld,
    input  logic [W-1:0]               push_dat,
    input  logic                       pop,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       head_vld,
    output logic [W-1:0]               head_dat
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            // Flush wins over any push/pop in the same cycle.
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_vld) wr_ptr <= wr_ptr + PW'(1);
            if (pop)      rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push_vld) - CW'(pop);
        end
    end

    // Storage needs no reset: the head is masked by count.
    always_ff @(posedge clk) begin
        if (push_vld && !flush) mem[wr_ptr] <= push_dat;
    end

    assign head_vld = (count != '0);
    assign head_dat = head_vld ? mem[rd_ptr] : '0;
endmodule

module mips_fetch_unit #(
    parameter int                ADDR_W  = 32,
    parameter int                DATA_W  = 32,
    parameter int                DEPTH   = 4,
    parameter logic [ADDR_W-1:0] PC_INIT = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_en,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [DATA_W-1:0] imem_rsp_data,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [ADDR_W-1:0] instr_pc,
    output logic [DATA_W-1:0] instr_data
);
    localparam int CW = $clog2(DEPTH+1);

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] instr;
    } fetch_ent_t;

    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] rsp_pc;
    logic [CW-1:0]     inflight;
    logic [CW-1:0]     drop;
    logic [CW-1:0]     count;
    logic [CW-1:0]     inflight_nxt;
    logic [CW:0]       credit_sum;
    logic [ADDR_W-1:0] redirect_aligned;
    logic              req_fire;
    logic              rsp_fire;
    logic              push;
    logic              pop;
    fetch_ent_t        push_ent;
    fetch_ent_t        head_ent;

    // Every outstanding request owns a FIFO slot, so a returning word can never find the FIFO full.
    assign credit_sum     = {1'b0, count} + {1'b0, inflight};
    // Gated by reset so the port reads idle while reset is held, without waiting for an edge.
    assign imem_req_valid = reset & fetch_en & (credit_sum < (CW+1)'(DEPTH));
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid & imem_req_ready;

    // A response with nothing outstanding is a protocol error and is ignored.
    assign rsp_fire       = imem_rsp_valid & (inflight != '0);
    // Responses landing in a redirect cycle belong to the old stream and are never pushed.
    assign push           = rsp_fire & (drop == '0) & ~redirect_valid;
    assign pop            = instr_valid & instr_ready;

    assign inflight_nxt     = inflight + CW'(req_fire) - CW'(rsp_fire);
    assign redirect_aligned = {redirect_pc[ADDR_W-1:2], 2'b00};

    assign push_ent.pc    = rsp_pc;
    assign push_ent.instr = imem_rsp_data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc <= PC_INIT;
            rsp_pc   <= PC_INIT;
            inflight <= '0;
            drop     <= '0;
        end else begin
            inflight <= inflight_nxt;
            if (redirect_valid) begin
                fetch_pc <= redirect_aligned;
                rsp_pc   <= redirect_aligned;
                // Everything still outstanding after this edge, including a request
                // accepted this cycle at the old PC, belongs to the abandoned stream.
                drop     <= inflight_nxt;
            end else begin
                if (req_fire) fetch_pc <= fetch_pc + ADDR_W'(4);
                if (rsp_fire) begin
                    if (drop != '0) drop   <= drop - CW'(1);
                    else            rsp_pc <= rsp_pc + ADDR_W'(4);
                end
            end
        end
    end

    mips_fetch_fifo #(
        .W     (ADDR_W + DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .flush    (redirect_valid),
        .push_vld (push),
        .push_dat (push_ent),
        .pop      (pop),
        .count    (count),
        .head_vld (instr_valid),
        .head_dat (head_ent)
    );

    assign instr_pc   = head_ent.pc;
    assign instr_data = head_ent.instr;

    a_drop_le_inflight: assert property (@(posedge clk) disable iff (!reset) drop <= inflight);
    a_credit_bound:     assert property (@(posedge clk) disable iff (!reset) credit_sum <= (CW+1)'(DEPTH));
endmodule

// File: tb/tb_mips_fetch_unit.sv
module tb_mips_fetch_unit;
    localparam int          DEPTH   = 4;
    localparam logic [31:0] PC_INIT = 32'h400;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        fetch_en = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr_pc;
    logic [31:0] instr_data;

    always #5 clk = ~clk;

    mips_fetch_unit #(
        .ADDR_W (32), .DATA_W (32), .DEPTH (DEPTH), .PC_INIT (PC_INIT)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_pc       (instr_pc),
        .instr_data     (instr_data)
    );

    // Reference model: expected decode stream, outstanding requests tagged stale or live.
    typedef struct { logic [31:0] pc; logic [31:0] data; } ent_t;
    typedef struct { logic [31:0] addr; bit stale; } out_t;
    typedef struct { logic [31:0] addr; int due; } mreq_t;

    ent_t        exp_q[$];
    out_t        out_q[$];
    logic [31:0] next_pc;
    mreq_t       mem_q[$];
    int          last_due;
    int          cyc = 0;

    int n_checks = 0;
    int n_fail   = 0;

    // Stimulus knobs.
    bit          d_fetch_en, d_req_ready, d_instr_ready, d_redirect, d_stray;
    logic [31:0] d_redirect_pc;
    int          d_lat_min = 1, d_lat_max = 1;

    // Observations from the last cycle.
    bit          s_req_fire, s_req_valid, s_pop;
    logic [31:0] s_req_addr, s_pc;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h00C0FFEE;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        out_q.delete();
        mem_q.delete();
        next_pc  = PC_INIT;
        last_due = -1;
    endtask

    task automatic cycle();
        bit          m_req, m_rsp, m_pop, from_mem, st;
        out_t        o;
        logic [31:0] ra;
        int          due;
        @(negedge clk);
        fetch_en       = d_fetch_en;
        imem_req_ready = d_req_ready;
        instr_ready    = d_instr_ready;
        redirect_valid = d_redirect;
        redirect_pc    = d_redirect_pc;
        from_mem = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
        if (from_mem) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = memfn(mem_q[0].addr);
        end else begin
            imem_rsp_valid = d_stray;
            imem_rsp_data  = $urandom;
        end
        #1;
        m_req = d_fetch_en && (exp_q.size() + out_q.size() < DEPTH);
        check("req_valid",   {31'b0, imem_req_valid}, {31'b0, m_req});
        check("req_addr",    imem_req_addr, next_pc);
        check("instr_valid", {31'b0, instr_valid}, {31'b0, exp_q.size() != 0});
        check("instr_pc",    instr_pc,   (exp_q.size() != 0) ? exp_q[0].pc   : 32'h0);
        check("instr_data",  instr_data, (exp_q.size() != 0) ? exp_q[0].data : 32'h0);
        s_req_valid = imem_req_valid;
        s_req_fire  = imem_req_valid && imem_req_ready;
        s_req_addr  = imem_req_addr;
        s_pop       = instr_valid && instr_ready;
        s_pc        = instr_pc;

        // Memory environment: in-order, one response per cycle, latency d_lat_min..d_lat_max.
        if (from_mem) void'(mem_q.pop_front());
        if (s_req_fire) begin
            due = cyc + $urandom_range(d_lat_max, d_lat_min);
            if (due <= last_due) due = last_due + 1;
            mem_q.push_back('{imem_req_addr, due});
            last_due = due;
        end

        // Model step.
        m_req = m_req && d_req_ready;
        m_rsp = imem_rsp_valid && (out_q.size() != 0);
        m_pop = (exp_q.size() != 0) && d_instr_ready;
        st = 1'b1;
        ra = '0;
        if (m_rsp) begin
            o  = out_q.pop_front();
            st = o.stale;
            ra = o.addr;
        end
        if (d_redirect) begin
            exp_q.delete();
            foreach (out_q[i]) out_q[i].stale = 1'b1;
            if (m_req) out_q.push_back('{next_pc, 1'b1});
            next_pc = {d_redirect_pc[31:2], 2'b00};
        end else begin
            if (m_pop) void'(exp_q.pop_front());
            if (m_rsp && !st) exp_q.push_back('{ra, memfn(ra)});
            if (m_req) begin
                out_q.push_back('{next_pc, 1'b0});
                next_pc = next_pc + 32'd4;
            end
        end
        @(posedge clk);
        cyc++;
    endtask

    // Assert reset between edges, check outputs at once, hold across an edge, release.
    task automatic reset_mid();
        #2;
        reset          = 1'b0;
        fetch_en       = 1'b1;
        imem_rsp_valid = 1'b0;
        #1;
        check("rst_req_valid",   {31'b0, imem_req_valid}, 32'h0);
        check("rst_req_addr",    imem_req_addr, PC_INIT);
        check("rst_instr_valid", {31'b0, instr_valid}, 32'h0);
        check("rst_instr_pc",    instr_pc, 32'h0);
        check("rst_instr_data",  instr_data, 32'h0);
        @(posedge clk);
        #1;
        check("rst_hold_valid",  {31'b0, imem_req_valid}, 32'h0);
        #1;
        reset = 1'b1;
        model_clear();
    endtask

    task automatic wait_pop(output logic [31:0] pc);
        bit got = 1'b0;
        pc = 32'hDEADBEEF;
        for (int i = 0; i < 20 && !got; i++) begin
            cycle();
            if (s_pop) begin
                got = 1'b1;
                pc  = s_pc;
            end
        end
    endtask

    task automatic knobs(input bit fe, input bit rr, input bit ir, input int lmin, input int lmax);
        d_fetch_en = fe; d_req_ready = rr; d_instr_ready = ir;
        d_lat_min = lmin; d_lat_max = lmax;
        d_redirect = 1'b0; d_stray = 1'b0; d_redirect_pc = '0;
    endtask

    initial begin
        logic [31:0] pc;
        logic [31:0] got_addr[$];
        int          n;

        model_clear();
        @(posedge clk);
        reset_mid();

        // 1: streaming, 1-cycle memory.
        knobs(1, 1, 1, 1, 1);
        cycle();
        check("t1_first_req", s_req_addr, 32'h400);
        wait_pop(pc);
        check("t1_first_pc", pc, 32'h400);
        n = 0;
        for (int i = 0; i < 20; i++) begin cycle(); if (s_pop) n++; end
        check("t1_throughput", n, 20);

        // 4: redirect while a request and a response both fire.
        d_redirect = 1'b1; d_redirect_pc = 32'h2000;
        cycle();
        d_redirect = 1'b0;
        wait_pop(pc);
        check("t4_first_pc", pc, 32'h2000);
        d_fetch_en = 1'b0;
        repeat (10) cycle();
        d_fetch_en = 1'b1;
        cycle();
        check("t4_credit_back", {31'b0, s_req_valid}, 32'h1);

        // 2: decode stalled, memory always ready.
        reset_mid();
        knobs(1, 1, 0, 1, 1);
        n = 0;
        for (int i = 0; i < 12; i++) begin cycle(); if (s_req_fire) n++; end
        check("t2_req_count", n, DEPTH);
        check("t2_req_stopped", {31'b0, s_req_valid}, 32'h0);
        d_instr_ready = 1'b1;
        wait_pop(pc);
        check("t2_first_pc", pc, 32'h400);
        repeat (10) cycle();

        // 3: 3-cycle memory, redirect with 3 in flight.
        reset_mid();
        knobs(1, 1, 1, 3, 3);
        repeat (3) cycle();
        d_redirect = 1'b1; d_redirect_pc = 32'h1000;
        cycle();
        d_redirect = 1'b0;
        wait_pop(pc);
        check("t3_first_pc", pc, 32'h1000);

        // 5: misaligned target and address wrap.
        knobs(1, 1, 1, 1, 2);
        d_redirect = 1'b1; d_redirect_pc = 32'h1003;
        cycle();
        d_redirect = 1'b0;
        cycle();
        check("t5_aligned", s_req_addr, 32'h1000);
        d_redirect = 1'b1; d_redirect_pc = 32'hFFFFFFFC;
        cycle();
        d_redirect = 1'b0;
        got_addr.delete();
        for (int i = 0; i < 20 && got_addr.size() < 2; i++) begin
            cycle();
            if (s_req_fire) got_addr.push_back(s_req_addr);
        end
        got_addr.push_back(32'hDEADBEEF);
        got_addr.push_back(32'hDEADBEEF);
        check("t5_wrap_a", got_addr[0], 32'hFFFFFFFC);
        check("t5_wrap_b", got_addr[1], 32'h00000000);
        repeat (5) cycle();

        // 6: reset with 2 in flight, then a stray response.
        reset_mid();
        knobs(1, 1, 1, 3, 3);
        repeat (2) cycle();
        reset_mid();
        d_stray = 1'b1;
        cycle();
        d_stray = 1'b0;
        check("t6_first_req", s_req_addr, PC_INIT);
        check("t6_first_valid", {31'b0, s_req_valid}, 32'h1);
        repeat (8) cycle();

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            d_fetch_en    = ($urandom_range(9, 0) != 0);
            d_req_ready   = ($urandom_range(9, 0) < 7);
            d_instr_ready = ($urandom_range(3, 0) != 0);
            d_redirect    = ($urandom_range(19, 0) == 0);
            d_redirect_pc = $urandom;
            d_lat_min     = 1;
            d_lat_max     = $urandom_range(4, 1);
            cycle();
            if (i % 700 == 699) reset_mid();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
